// File: rtl/amm_slave_scratchpad.sv
// amm_slave_scratchpad: Avalon-MM scratchpad slave with write wait-states, pipelined reads and a monitor port
// Define AMM_SLAVE_PERF_CNT_EN to map read/write counters at DEPTH and DEPTH+1.
module amm_slave_scratchpad #(
  parameter int          ADDR_W       = 8,
  parameter int          DEPTH        = 64,
  parameter int          READ_LATENCY = 2,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BAD_DATA     = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic [31:0]       mon_data,
  output logic              err_sticky,
  input  logic              err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] A_RC = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] A_WC = ADDR_W'(DEPTH + 1);
  logic [31:0] mem [DEPTH];
  logic [2:0] wcnt;
  logic commit, rd_acc, ram_hit, perf_hit, err_set;
  logic [31:0] rd_word, mon_word;
  logic [READ_LATENCY-1:0] pv;
  logic [31:0] pd [READ_LATENCY];
  function automatic logic [31:0] ram_at(input logic [ADDR_W-1:0] a);
    return (a < A_RC) ? mem[a[AW-1:0]] : BAD_DATA;
  endfunction
  assign avs_waitrequest = avs_write && (wcnt != 3'(WAIT_STATES));
  assign commit = avs_write && !avs_waitrequest;
  assign rd_acc = avs_read && !avs_write;
  assign ram_hit = avs_address < A_RC;
`ifdef AMM_SLAVE_PERF_CNT_EN
  logic [31:0] rd_cnt, wr_cnt;
  assign perf_hit = (avs_address == A_RC) || (avs_address == A_WC);
  // the read of rd_cnt counts itself, so it returns the post-increment value
  assign rd_word = (avs_address == A_RC) ? rd_cnt + 32'd1 : (avs_address == A_WC) ? wr_cnt : ram_at(avs_address);
  assign mon_word = (mon_addr == A_RC) ? rd_cnt : (mon_addr == A_WC) ? wr_cnt : ram_at(mon_addr);
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_acc) rd_cnt <= rd_cnt + 32'd1;
      else if (commit && avs_address == A_RC) rd_cnt <= '0;
      if (commit) wr_cnt <= (avs_address == A_WC) ? '0 : wr_cnt + 32'd1;
    end
  end
`else
  assign perf_hit = 1'b0;
  assign rd_word = ram_at(avs_address);
  assign mon_word = ram_at(mon_addr);
`endif
  assign err_set = (avs_read && avs_write) || ((rd_acc || commit) && !ram_hit && !perf_hit);
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
      err_sticky <= 1'b0;
      mon_data <= '0;
    end else begin
      wcnt <= avs_waitrequest ? wcnt + 3'd1 : 3'd0;
      err_sticky <= err_set || (err_sticky && !err_clr);
      mon_data <= mon_word;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && commit && ram_hit)
      for (int b = 0; b < 4; b++)
        if (avs_byteenable[b]) mem[avs_address[AW-1:0]][8*b +: 8] <= avs_writedata[8*b +: 8];
  end
  // data stages only load behind a valid bit, so the last stage holds between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) pd[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end
  assign avs_readdatavalid = pv[READ_LATENCY-1];
  assign avs_readdata = pd[READ_LATENCY-1];
endmodule

// File: tb/tb_amm_slave_scratchpad.sv
// tb_amm_slave_scratchpad: directed checks of the scratchpad slave with hand-computed expectations
module tb_amm_slave_scratchpad;
  logic clk = 1'b0;
  logic reset, avs_read, avs_write, err_clr;
  logic [7:0] avs_address, mon_addr;
  logic [31:0] avs_writedata, avs_readdata, mon_data;
  logic [3:0] avs_byteenable;
  logic avs_waitrequest, avs_readdatavalid, err_sticky;
  int checks = 0, errors = 0;

  amm_slave_scratchpad dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .mon_addr(mon_addr), .mon_data(mon_data),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, output int st);
    avs_address = a;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    st = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      st++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output int lat);
    avs_address = a;
    avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    lat = 0;
    d = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (avs_readdatavalid) begin
        d = avs_readdata;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int lat, st, cnt;
    logic [31:0] got_d[$];
    int got_k[$];
    avs_read = 0; avs_write = 0; err_clr = 0; avs_address = 0; mon_addr = 0;
    avs_writedata = 0; avs_byteenable = 0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_valid", {31'd0, avs_readdatavalid}, 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    chk("rst_mon", mon_data, 32'd0);
    chk("rst_err", {31'd0, err_sticky}, 32'd0);
    chk("rst_wait", {31'd0, avs_waitrequest}, 32'd0);
    @(posedge clk); #1;

    wr(8'd5, 32'h11223344, 4'hF, st);
    chk("t1_stall_a", st, 2);
    wr(8'd5, 32'hAABBCCDD, 4'b0101, st);
    chk("t1_stall_b", st, 2);
    rd(8'd5, d, lat);
    chk("t1_data", d, 32'h11BB33DD);
    chk("t1_lat", lat, 2);
    @(negedge clk);
    chk("t1_hold_valid", {31'd0, avs_readdatavalid}, 32'd0);
    chk("t1_hold_data", avs_readdata, 32'h11BB33DD);
    @(posedge clk); #1;
    mon_addr = 8'd5;
    @(posedge clk); #1;
    chk("mon_5", mon_data, 32'h11BB33DD);

    for (int k = 0; k < 4; k++) wr(8'(k), 32'h10 + 32'(k), 4'hF, st);
    for (int k = 0; k < 8; k++) begin
      avs_read = (k < 4);
      avs_address = 8'(k);
      @(negedge clk);
      if (avs_readdatavalid) begin
        got_d.push_back(avs_readdata);
        got_k.push_back(k);
      end
      @(posedge clk); #1;
    end
    avs_read = 0;
    chk("t2_count", got_d.size(), 4);
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      chk($sformatf("t2_data%0d", i), got_d[i], 32'h10 + 32'(i));
      chk($sformatf("t2_cyc%0d", i), got_k[i], i + 2);
    end

    wr(8'd10, 32'h77, 4'hF, st);
    avs_address = 8'd10; avs_writedata = 32'h99; avs_byteenable = 4'hF; avs_write = 1;
    @(posedge clk); #1;
    avs_write = 0;
    @(posedge clk); #1;
    rd(8'd10, d, lat);
    chk("abort_data", d, 32'h77);
    wr(8'd11, 32'h1, 4'hF, st);
    chk("abort_wcnt", st, 2);
    chk("abort_err", {31'd0, err_sticky}, 32'd0);

    rd(8'd200, d, lat);
    chk("t3_bad", d, 32'hDEADBEEF);
    chk("t3_err", {31'd0, err_sticky}, 32'd1);
    err_clr = 1; avs_read = 1; avs_address = 8'd200;
    @(posedge clk); #1;
    err_clr = 0; avs_read = 0;
    chk("t3_set_wins", {31'd0, err_sticky}, 32'd1);
    repeat (3) @(posedge clk);
    #1 err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("t3_clr", {31'd0, err_sticky}, 32'd0);
    mon_addr = 8'd200;
    @(posedge clk); #1;
    chk("mon_bad", mon_data, 32'hDEADBEEF);
    chk("mon_no_err", {31'd0, err_sticky}, 32'd0);

    rd(8'd200, d, lat);
    mon_addr = 8'd5;
    avs_address = 8'd7; avs_read = 1;
    @(posedge clk); #1;
    avs_read = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("t4_valid", {31'd0, avs_readdatavalid}, 32'd0);
    chk("t4_rdata", avs_readdata, 32'd0);
    chk("t4_err", {31'd0, err_sticky}, 32'd0);
    chk("t4_mon", mon_data, 32'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (avs_readdatavalid) cnt++;
    end
    chk("t4_no_valid", cnt, 0);
    chk("t4_mem_kept", mon_data, 32'h11BB33DD);
    @(posedge clk); #1;

    avs_read = 1;
    cnt = 0;
    fork
      wr(8'd9, 32'h5A5A5A5A, 4'hF, st);
      repeat (4) begin
        @(negedge clk);
        if (avs_readdatavalid) cnt++;
      end
    join
    avs_read = 0;
    repeat (3) begin
      @(negedge clk);
      if (avs_readdatavalid) cnt++;
    end
    @(posedge clk); #1;
    chk("t5_stall", st, 2);
    chk("t5_no_valid", cnt, 0);
    chk("t5_err", {31'd0, err_sticky}, 32'd1);
    rd(8'd9, d, lat);
    chk("t5_data", d, 32'h5A5A5A5A);

    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    wr(8'd150, 32'h12345678, 4'hF, st);
    chk("unmap_wr_stall", st, 2);
    chk("unmap_wr_err", {31'd0, err_sticky}, 32'd1);

    do_reset();
`ifdef AMM_SLAVE_PERF_CNT_EN
    for (int k = 0; k < 3; k++) rd(8'(k), d, lat);
    wr(8'd20, 32'h1, 4'hF, st);
    wr(8'd21, 32'h2, 4'hF, st);
    rd(8'd64, d, lat);
    chk("t6_rd_cnt", d, 32'd4);
    rd(8'd65, d, lat);
    chk("t6_wr_cnt", d, 32'd2);
    wr(8'd65, 32'hFFFF, 4'hF, st);
    rd(8'd65, d, lat);
    chk("t6_wr_clr", d, 32'd0);
    chk("t6_err", {31'd0, err_sticky}, 32'd0);
`else
    rd(8'd64, d, lat);
    chk("t6_unmapped", d, 32'hDEADBEEF);
    chk("t6_err", {31'd0, err_sticky}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
